// File: rtl/sram_like_arbiter.sv
// N-channel sram-like arbiter: merges master ports onto one slave port, tracks
// outstanding transactions in an in-order id FIFO and routes responses back.
module sram_like_arbiter_lane #(
  parameter int IDW = 1,
  parameter int ID  = 0
) (
  input  logic           hs,
  input  logic           pop,
  input  logic [IDW-1:0] grant,
  input  logic [IDW-1:0] head,
  output logic           addr_ok,
  output logic           data_ok
);
  assign addr_ok = hs  & (grant == IDW'(ID));
  assign data_ok = pop & (head  == IDW'(ID));
endmodule

module sram_like_arbiter #(
  parameter int NCH       = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4,
  parameter int RR        = 0
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [NCH-1:0]                 m_req,
  input  logic [NCH-1:0]                 m_wr,
  input  logic [NCH-1:0][1:0]            m_size,
  input  logic [NCH-1:0][DATA_W/8-1:0]   m_wstrb,
  input  logic [NCH-1:0][ADDR_W-1:0]     m_addr,
  input  logic [NCH-1:0][DATA_W-1:0]     m_wdata,
  output logic [NCH-1:0]                 m_addr_ok,
  output logic [NCH-1:0]                 m_data_ok,
  output logic [DATA_W-1:0]              m_rdata,
  output logic                           s_req,
  output logic                           s_wr,
  output logic [1:0]                     s_size,
  output logic [DATA_W/8-1:0]            s_wstrb,
  output logic [ADDR_W-1:0]              s_addr,
  output logic [DATA_W-1:0]              s_wdata,
  input  logic                           s_addr_ok,
  input  logic                           s_data_ok,
  input  logic [DATA_W-1:0]              s_rdata,
  output logic [$clog2(MAX_OUTST):0]     outst_cnt,
  output logic                           resp_err
);
  localparam int IDW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW  = $clog2(MAX_OUTST);
  localparam int CW  = PW + 1;

  logic [MAX_OUTST-1:0][IDW-1:0] fifo_q, fifo_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           lock_q, lock_d;
  logic [IDW-1:0] lock_id_q, lock_id_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic           resp_err_q, resp_err_d;

  logic [IDW-1:0] arb_gnt, grant, head;
  logic           found, enabled, hs, pop;

  always_comb begin
    arb_gnt = '0;
    found   = 1'b0;
    if (RR != 0) begin
      for (int k = 0; k < NCH; k++) begin
        if (!found && m_req[(int'(rr_ptr_q) + k) % NCH]) begin
          arb_gnt = IDW'((int'(rr_ptr_q) + k) % NCH);
          found   = 1'b1;
        end
      end
    end else begin
      // later (higher) indices overwrite earlier ones
      for (int i = 0; i < NCH; i++) begin
        if (m_req[i]) arb_gnt = IDW'(i);
      end
    end
  end

  assign grant   = lock_q ? lock_id_q : arb_gnt;
  assign enabled = cnt_q < CW'(MAX_OUTST);
  assign s_req   = resetn & enabled & (lock_q | (|m_req));
  assign hs      = s_req & s_addr_ok;
  // a response only ever retires an entry pushed in an earlier cycle
  assign pop     = resetn & s_data_ok & (cnt_q != '0);
  assign head    = fifo_q[rd_ptr_q];

  assign s_wr    = m_wr[grant];
  assign s_size  = m_size[grant];
  assign s_wstrb = m_wstrb[grant];
  assign s_addr  = m_addr[grant];
  assign s_wdata = m_wdata[grant];
  assign m_rdata = s_rdata;

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    sram_like_arbiter_lane #(.IDW(IDW), .ID(g)) u_lane (
      .hs      (hs),
      .pop     (pop),
      .grant   (grant),
      .head    (head),
      .addr_ok (m_addr_ok[g]),
      .data_ok (m_data_ok[g])
    );
  end

  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rr_ptr_d   = rr_ptr_q;
    lock_d     = s_req & ~s_addr_ok;
    lock_id_d  = s_req ? grant : lock_id_q;
    cnt_d      = cnt_q + CW'(hs) - CW'(pop);
    resp_err_d = resp_err_q | (s_data_ok & (cnt_q == '0));
    if (hs) begin
      fifo_d[wr_ptr_q] = grant;
      wr_ptr_d         = wr_ptr_q + 1'b1;
      if (RR != 0) rr_ptr_d = (grant == IDW'(NCH - 1)) ? '0 : grant + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fifo_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      lock_q     <= 1'b0;
      lock_id_q  <= '0;
      rr_ptr_q   <= '0;
      resp_err_q <= 1'b0;
    end else begin
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      lock_q     <= lock_d;
      lock_id_q  <= lock_id_d;
      rr_ptr_q   <= rr_ptr_d;
      resp_err_q <= resp_err_d;
    end
  end

  assign outst_cnt = cnt_q;
  assign resp_err  = resp_err_q;
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench: fixed-priority NCH=2 instance driven from a vector table,
// plus a round-robin NCH=4 instance and hand-written reset/error sequences.
module tb_sram_like_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] A0 = 32'h1C00_0000;
  localparam logic [31:0] A1 = 32'h1C00_0100;

  // fixed-priority instance, NCH=2
  logic [1:0]  f_req, f_wr, f_aok_m, f_dok_m;
  logic [63:0] f_addr, f_wdata;
  logic [3:0]  f_size;
  logic [7:0]  f_wstrb;
  logic [31:0] f_rdata_m, f_s_addr, f_s_wdata, f_s_rdata;
  logic        f_s_req, f_s_wr, f_s_aok, f_s_dok, f_err;
  logic [1:0]  f_s_size;
  logic [3:0]  f_s_wstrb;
  logic [2:0]  f_cnt;

  sram_like_arbiter #(.NCH(2), .MAX_OUTST(4), .RR(0)) u_fp (
    .clk(clk), .resetn(resetn), .m_req(f_req), .m_wr(f_wr), .m_size(f_size),
    .m_wstrb(f_wstrb), .m_addr(f_addr), .m_wdata(f_wdata), .m_addr_ok(f_aok_m),
    .m_data_ok(f_dok_m), .m_rdata(f_rdata_m), .s_req(f_s_req), .s_wr(f_s_wr),
    .s_size(f_s_size), .s_wstrb(f_s_wstrb), .s_addr(f_s_addr), .s_wdata(f_s_wdata),
    .s_addr_ok(f_s_aok), .s_data_ok(f_s_dok), .s_rdata(f_s_rdata),
    .outst_cnt(f_cnt), .resp_err(f_err)
  );

  // round-robin instance, NCH=4
  logic [3:0]   r_req, r_wr, r_aok_m, r_dok_m;
  logic [127:0] r_addr, r_wdata;
  logic [7:0]   r_size;
  logic [15:0]  r_wstrb;
  logic [31:0]  r_rdata_m, r_s_addr, r_s_wdata, r_s_rdata;
  logic         r_s_req, r_s_wr, r_s_aok, r_s_dok, r_err;
  logic [1:0]   r_s_size;
  logic [3:0]   r_s_wstrb;
  logic [2:0]   r_cnt;

  sram_like_arbiter #(.NCH(4), .MAX_OUTST(4), .RR(1)) u_rr (
    .clk(clk), .resetn(resetn), .m_req(r_req), .m_wr(r_wr), .m_size(r_size),
    .m_wstrb(r_wstrb), .m_addr(r_addr), .m_wdata(r_wdata), .m_addr_ok(r_aok_m),
    .m_data_ok(r_dok_m), .m_rdata(r_rdata_m), .s_req(r_s_req), .s_wr(r_s_wr),
    .s_size(r_s_size), .s_wstrb(r_s_wstrb), .s_addr(r_s_addr), .s_wdata(r_s_wdata),
    .s_addr_ok(r_s_aok), .s_data_ok(r_s_dok), .s_rdata(r_s_rdata),
    .outst_cnt(r_cnt), .resp_err(r_err)
  );

  typedef struct {
    logic [1:0]  req, wr;
    logic        aok, dok;
    logic [31:0] rdata;
    logic        e_sreq;
    logic [31:0] e_addr;
    logic        e_wr;
    logic [1:0]  e_aok, e_dok;
    logic [2:0]  e_cnt;
    logic        e_err;
  } vec_t;

  vec_t vecs[29];

  function automatic vec_t mk(logic [1:0] req, logic [1:0] wr, logic aok, logic dok,
                              logic [31:0] rdata, logic e_sreq, logic [31:0] e_addr,
                              logic e_wr, logic [1:0] e_aok, logic [1:0] e_dok,
                              logic [2:0] e_cnt, logic e_err);
    vec_t v;
    v.req = req; v.wr = wr; v.aok = aok; v.dok = dok; v.rdata = rdata;
    v.e_sreq = e_sreq; v.e_addr = e_addr; v.e_wr = e_wr; v.e_aok = e_aok;
    v.e_dok = e_dok; v.e_cnt = e_cnt; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    f_req = '0; f_wr = '0; f_s_aok = 0; f_s_dok = 0; f_s_rdata = '0;
    f_addr = {A1, A0}; f_wdata = {32'hD1D1_D1D1, 32'hD0D0_D0D0};
    f_size = 4'b1010; f_wstrb = 8'hFF;
    r_req = '0; r_wr = '0; r_s_aok = 0; r_s_dok = 0; r_s_rdata = 32'h5555_0000;
    r_addr = {32'h300, 32'h200, 32'h100, 32'h000}; r_wdata = '0;
    r_size = 8'hAA; r_wstrb = 16'hFFFF;

    // reset state, with requests pending to confirm output gating
    f_req = 2'b01; f_s_aok = 1; f_s_dok = 1;
    #12;
    chk("rst_sreq", 64'(f_s_req), 64'd0);
    chk("rst_aok", 64'(f_aok_m), 64'd0);
    chk("rst_dok", 64'(f_dok_m), 64'd0);
    chk("rst_cnt", 64'(f_cnt), 64'd0);
    chk("rst_err", 64'(f_err), 64'd0);
    chk("rst_rr_cnt", 64'(r_cnt), 64'd0);
    f_req = '0; f_s_aok = 0; f_s_dok = 0;
    @(posedge clk); #2 resetn = 1;

    // round-robin: all requesting, every request accepted, responses drained
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      r_req = 4'hF; r_s_aok = 1; r_s_dok = (c > 0);
      #1;
      chk($sformatf("rr_aok%0d", c), 64'(r_aok_m), 64'(4'b0001 << (c % 4)));
      chk($sformatf("rr_addr%0d", c), 64'(r_s_addr), 64'(32'h100 * (c % 4)));
      chk($sformatf("rr_dok%0d", c), 64'(r_dok_m),
          (c > 0) ? 64'(4'b0001 << ((c - 1) % 4)) : 64'd0);
    end
    @(posedge clk); #1;
    chk("rr_cnt5", 64'(r_cnt), 64'd1);
    r_req = '0; r_s_aok = 0; r_s_dok = 1;
    #1 chk("rr_dok_last", 64'(r_dok_m), 64'd1);
    @(posedge clk); #1;
    r_s_dok = 0;
    chk("rr_cnt_end", 64'(r_cnt), 64'd0);
    chk("rr_err", 64'(r_err), 64'd0);

    vecs[0]  = mk(2'b01, 2'b00, 1, 0, 32'h0,        1, A0, 0, 2'b01, 2'b00, 1, 0);
    vecs[1]  = mk(2'b00, 2'b00, 0, 0, 32'h0,        0, A0, 0, 2'b00, 2'b00, 1, 0);
    vecs[2]  = mk(2'b00, 2'b00, 0, 1, 32'h1234_5678, 0, A0, 0, 2'b00, 2'b01, 0, 0);
    vecs[3]  = mk(2'b01, 2'b00, 0, 0, 32'h0,        1, A0, 0, 2'b00, 2'b00, 0, 0);
    vecs[4]  = mk(2'b11, 2'b00, 0, 0, 32'h0,        1, A0, 0, 2'b00, 2'b00, 0, 0);
    vecs[5]  = mk(2'b11, 2'b00, 0, 0, 32'h0,        1, A0, 0, 2'b00, 2'b00, 0, 0);
    vecs[6]  = mk(2'b11, 2'b00, 1, 0, 32'h0,        1, A0, 0, 2'b01, 2'b00, 1, 0);
    vecs[7]  = mk(2'b10, 2'b00, 1, 0, 32'h0,        1, A1, 0, 2'b10, 2'b00, 2, 0);
    vecs[8]  = mk(2'b00, 2'b00, 0, 1, 32'hAAAA,     0, A0, 0, 2'b00, 2'b01, 1, 0);
    vecs[9]  = mk(2'b00, 2'b00, 0, 1, 32'hBBBB,     0, A0, 0, 2'b00, 2'b10, 0, 0);
    vecs[10] = mk(2'b10, 2'b10, 1, 0, 32'h0,        1, A1, 1, 2'b10, 2'b00, 1, 0);
    vecs[11] = mk(2'b01, 2'b00, 1, 0, 32'h0,        1, A0, 0, 2'b01, 2'b00, 2, 0);
    vecs[12] = mk(2'b10, 2'b00, 1, 0, 32'h0,        1, A1, 0, 2'b10, 2'b00, 3, 0);
    vecs[13] = mk(2'b00, 2'b00, 0, 1, 32'hA,        0, A0, 0, 2'b00, 2'b10, 2, 0);
    vecs[14] = mk(2'b10, 2'b00, 1, 1, 32'hB,        1, A1, 0, 2'b10, 2'b01, 2, 0);
    vecs[15] = mk(2'b00, 2'b00, 0, 1, 32'hC,        0, A0, 0, 2'b00, 2'b10, 1, 0);
    vecs[16] = mk(2'b00, 2'b00, 0, 1, 32'hD,        0, A0, 0, 2'b00, 2'b10, 0, 0);
    for (int k = 0; k < 4; k++)
      vecs[17+k] = mk(2'b01, 2'b00, 1, 0, 32'h0, 1, A0, 0, 2'b01, 2'b00, 3'(k + 1), 0);
    vecs[21] = mk(2'b01, 2'b00, 1, 0, 32'h0,        0, A0, 0, 2'b00, 2'b00, 4, 0);
    vecs[22] = mk(2'b01, 2'b00, 1, 1, 32'hE,        0, A0, 0, 2'b00, 2'b01, 3, 0);
    vecs[23] = mk(2'b01, 2'b00, 1, 0, 32'h0,        1, A0, 0, 2'b01, 2'b00, 4, 0);
    for (int k = 0; k < 4; k++)
      vecs[24+k] = mk(2'b00, 2'b00, 0, 1, 32'hF0 + k, 0, A0, 0, 2'b00, 2'b01, 3'(3 - k), 0);
    vecs[28] = mk(2'b00, 2'b00, 0, 1, 32'h0,        0, A0, 0, 2'b00, 2'b00, 0, 1);

    for (int i = 0; i < 29; i++) begin
      f_req = vecs[i].req; f_wr = vecs[i].wr; f_s_aok = vecs[i].aok;
      f_s_dok = vecs[i].dok; f_s_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d_sreq", i), 64'(f_s_req), 64'(vecs[i].e_sreq));
      if (vecs[i].e_sreq) begin
        chk($sformatf("v%0d_saddr", i), 64'(f_s_addr), 64'(vecs[i].e_addr));
        chk($sformatf("v%0d_swr", i), 64'(f_s_wr), 64'(vecs[i].e_wr));
      end
      chk($sformatf("v%0d_aok", i), 64'(f_aok_m), 64'(vecs[i].e_aok));
      chk($sformatf("v%0d_dok", i), 64'(f_dok_m), 64'(vecs[i].e_dok));
      if (vecs[i].e_dok != 2'b00)
        chk($sformatf("v%0d_rdata", i), 64'(f_rdata_m), 64'(vecs[i].rdata));
      @(posedge clk); #1;
      chk($sformatf("v%0d_cnt", i), 64'(f_cnt), 64'(vecs[i].e_cnt));
      chk($sformatf("v%0d_err", i), 64'(f_err), 64'(vecs[i].e_err));
    end

    // reset mid-burst with three outstanding
    f_req = 2'b01; f_s_aok = 1; f_s_dok = 0;
    repeat (3) @(posedge clk);
    #1 chk("mid_cnt3", 64'(f_cnt), 64'd3);
    f_s_dok = 1;
    #2 resetn = 0;
    #1;
    chk("mid_cnt0", 64'(f_cnt), 64'd0);
    chk("mid_err0", 64'(f_err), 64'd0);
    chk("mid_sreq", 64'(f_s_req), 64'd0);
    chk("mid_aok", 64'(f_aok_m), 64'd0);
    chk("mid_dok", 64'(f_dok_m), 64'd0);
    f_req = '0; f_s_aok = 0; f_s_dok = 0;
    @(posedge clk); #2 resetn = 1;
    @(posedge clk); #1;
    chk("post_cnt", 64'(f_cnt), 64'd0);
    f_s_dok = 1;
    #1 chk("late_dok", 64'(f_dok_m), 64'd0);
    @(posedge clk); #1;
    f_s_dok = 0;
    chk("late_err", 64'(f_err), 64'd1);
    chk("late_cnt", 64'(f_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
